// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the CPU run sequencer: FSM states, the ecall opcode and halt codes.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StReady,
    StRun,
    StDone
  } seq_state_e;

  localparam logic [31:0] InstrEcall = 32'h0000_0073;

  typedef enum logic [1:0] {
    HaltNone  = 2'b00,
    HaltEcall = 2'b01,
    HaltLoop  = 2'b10,
    HaltLimit = 2'b11
  } halt_code_e;

endpackage

// File: rtl/halt_detector.sv
// Prioritised halt detection for a running CPU: ecall, PC self-loop, cycle limit.
module halt_detector
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      cpu_pc,
  input  logic [31:0]      cpu_instr,
  input  logic [CNT_W-1:0] cycle_now,
  input  logic [CNT_W-1:0] cycle_limit,
  output logic             halt,
  output halt_code_e       code
);

  logic [31:0] prev_pc_q;
  logic        pc_valid_q;

  // pc_valid_q is low in the first RUN cycle since the previous cycle was not RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pc_q  <= '0;
      pc_valid_q <= 1'b0;
    end else begin
      prev_pc_q  <= cpu_pc;
      pc_valid_q <= run;
    end
  end

  always_comb begin
    halt = 1'b0;
    code = HaltNone;
    if (run) begin
      if (cpu_instr == InstrEcall) begin
        halt = 1'b1;
        code = HaltEcall;
      end else if (pc_valid_q && (cpu_pc == prev_pc_q)) begin
        halt = 1'b1;
        code = HaltLoop;
      end else if ((cycle_limit != '0) && (cycle_now == cycle_limit)) begin
        halt = 1'b1;
        code = HaltLimit;
      end
    end
  end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Loads a program into instruction memory from a host stream, then runs the CPU until it halts.
module cpu_run_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  input  logic [31:0]       host_data,
  output logic              host_ready,
  input  logic              host_last,
  input  logic              go,
  input  logic [CNT_W-1:0]  cycle_limit,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  input  logic [31:0]       cpu_pc,
  input  logic [31:0]       cpu_instr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_code,
  output logic [CNT_W-1:0]  cycles
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_start_q, cpu_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  halt_code_e        halt_code_q, halt_code_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;

  logic              accept;
  logic              run;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  cycle_now;
  logic              halt;
  halt_code_e        code;

  assign host_ready = (state_q != StRun);
  assign accept     = host_valid && host_ready;
  assign run        = (state_q == StRun);
  // Any beat outside LOAD starts a fresh program at address 0.
  assign wr_addr    = (state_q == StLoad) ? load_ptr_q : '0;
  // Count including the current RUN cycle, saturating at all-ones.
  assign cycle_now  = (&cycles_q) ? cycles_q : cycles_q + 1'b1;

  halt_detector #(
    .CNT_W(CNT_W)
  ) u_halt_detector (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .cpu_pc     (cpu_pc),
    .cpu_instr  (cpu_instr),
    .cycle_now  (cycle_now),
    .cycle_limit(cycle_limit),
    .halt       (halt),
    .code       (code)
  );

  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_start_d  = cpu_start_q;
    halt_code_d  = halt_code_q;
    cycles_d     = cycles_q;

    if (accept) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = wr_addr;
      imem_wdata_d = host_data;
      load_ptr_d   = wr_addr + 1'b1;
      // The top address ends the load so the pointer never wraps onto address 0.
      state_d      = (host_last || (&wr_addr)) ? StReady : StLoad;
    end else if (go && ((state_q == StReady) || (state_q == StDone))) begin
      cycles_d    = '0;
      halt_code_d = HaltNone;
      cpu_start_d = 1'b1;
      state_d     = StRun;
    end

    if (run) begin
      cycles_d = cycle_now;
      if (halt) begin
        cpu_start_d = 1'b0;
        halt_code_d = code;
        state_d     = StDone;
      end
    end

    busy_d = (state_d == StLoad) || (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      load_ptr_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      halt_code_q  <= HaltNone;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_start_q  <= cpu_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      halt_code_q  <= halt_code_d;
      cycles_q     <= cycles_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_start  = cpu_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign halt_code  = halt_code_q;
  assign cycles     = cycles_q;

endmodule
